// File: rtl/counter_pkg.sv
// Shared types for the up/down counter: operating modes and one-shot FSM states.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } os_state_t;

endpackage

// File: rtl/counter_step.sv
// Combinational range arithmetic for one counter step: wraps or clips at 0..MAX_VAL
// and flags when the unbounded result fell outside that range.
module counter_step #(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 2**WIDTH-1,
  parameter int STEP    = 1
) (
  input  logic [WIDTH-1:0] count,
  input  logic             direction,
  input  logic             sat,
  output logic [WIDTH-1:0] next,
  output logic             boundary
);

  // One extra bit so count+STEP and MAX_VAL+1 never overflow.
  localparam logic [WIDTH:0] MAX_W    = MAX_VAL[WIDTH:0];
  localparam logic [WIDTH:0] STEP_W   = STEP[WIDTH:0];
  localparam logic [WIDTH:0] MODULUS  = MAX_W + 1'b1;
  localparam logic [WIDTH:0] DOWN_ADJ = MODULUS - STEP_W;

  logic [WIDTH:0] ext;
  logic [WIDTH:0] up_sum;

  always_comb begin
    ext      = {1'b0, count};
    up_sum   = ext + STEP_W;
    boundary = 1'b0;
    next     = count;
    if (direction) begin
      boundary = (up_sum > MAX_W);
      if (!boundary)  next = WIDTH'(up_sum);
      else if (sat)   next = WIDTH'(MAX_W);
      else            next = WIDTH'(up_sum - MODULUS);
    end else begin
      boundary = (ext < STEP_W);
      if (!boundary)  next = WIDTH'(ext - STEP_W);
      else if (sat)   next = '0;
      else            next = WIDTH'(ext + DOWN_ADJ);
    end
  end

endmodule

// File: rtl/updown_counter_ctrl.sv
// Parametrised up/down counter with load clipping, wrap/saturate/one-shot/hold modes
// and a registered terminal-count pulse.
module updown_counter_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 2**WIDTH-1,
  parameter int STEP    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             direction,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MAX_C = MAX_VAL[WIDTH-1:0];

  mode_t            cur_mode;
  os_state_t        state, state_n;
  logic [WIDTH-1:0] count_q, count_n;
  logic [WIDTH-1:0] step_next;
  logic [WIDTH-1:0] load_clip;
  logic [WIDTH-1:0] terminal;
  logic             step_oor;
  logic             tc_n;

  assign cur_mode  = mode_t'(mode);
  assign load_clip = (load_value > MAX_C) ? MAX_C : load_value;
  assign terminal  = direction ? MAX_C : '0;
  assign count_out = count_q;

  // Everything except plain wrap uses clipping arithmetic (one-shot runs saturate).
  counter_step #(
    .WIDTH  (WIDTH),
    .MAX_VAL(MAX_VAL),
    .STEP   (STEP)
  ) u_step (
    .count    (count_q),
    .direction(direction),
    .sat      (cur_mode != MODE_WRAP),
    .next     (step_next),
    .boundary (step_oor)
  );

  always_comb begin
    count_n = count_q;
    tc_n    = 1'b0;
    state_n = (cur_mode == MODE_ONESHOT) ? state : IDLE;
    if (load) begin
      count_n = load_clip;
      state_n = (cur_mode == MODE_ONESHOT) ? RUN : IDLE;
    end else begin
      case (cur_mode)
        MODE_WRAP, MODE_SAT: begin
          if (enable) begin
            count_n = step_next;
            tc_n    = step_oor;
          end
        end
        MODE_ONESHOT: begin
          // Only RUN advances; IDLE and DONE wait for a load.
          if (state == RUN && enable) begin
            count_n = step_next;
            if (step_next == terminal) begin
              state_n = DONE;
              tc_n    = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      tc      <= 1'b0;
      busy    <= 1'b0;
      state   <= IDLE;
    end else begin
      count_q <= count_n;
      tc      <= tc_n;
      busy    <= (state_n == RUN);
      state   <= state_n;
    end
  end

endmodule

// File: tb/tb_updown_counter_ctrl.sv
// Scoreboard bench: driver pushes model expectations, monitor pops and compares each cycle.
module tb_updown_counter_ctrl;

  localparam int W    = 8;
  localparam int MAXV = 9;
  localparam int STP  = 3;
  localparam int S_IDLE = 0, S_RUN = 1, S_DONE = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0, direction = 1'b0, load = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] load_value = '0;
  logic [W-1:0] count_out;
  logic         tc, busy;

  logic         d_enable = 1'b0, d_direction = 1'b0, d_load = 1'b0;
  logic [1:0]   d_mode = 2'b00;
  logic [7:0]   d_load_value = '0;
  logic [7:0]   d_count;
  logic         d_tc, d_busy;

  always #5 clk = ~clk;

  updown_counter_ctrl #(.WIDTH(W), .MAX_VAL(MAXV), .STEP(STP)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .direction(direction), .mode(mode),
    .load(load), .load_value(load_value), .count_out(count_out), .tc(tc), .busy(busy)
  );

  updown_counter_ctrl u_def (
    .clk(clk), .rst(rst), .enable(d_enable), .direction(d_direction), .mode(d_mode),
    .load(d_load), .load_value(d_load_value), .count_out(d_count), .tc(d_tc), .busy(d_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int cnt;
    bit tc;
    bit busy;
  } exp_t;

  exp_t sb[$];
  exp_t mon_x;

  // Reference model state: count as a plain integer, one-shot phase as an integer.
  int m_cnt = 0;
  int m_st  = S_IDLE;
  bit m_tc  = 1'b0;

  task automatic model(input bit e, input bit d, input bit [1:0] md, input bit l, input int lv);
    int nv;
    m_tc = 1'b0;
    if (l) begin
      m_cnt = (lv > MAXV) ? MAXV : lv;
      m_st  = (md == 2'd2) ? S_RUN : S_IDLE;
    end else begin
      if (md != 2'd2) m_st = S_IDLE;
      nv = d ? m_cnt + STP : m_cnt - STP;
      case (md)
        2'd0: if (e) begin
          if (nv > MAXV) begin nv = nv - (MAXV + 1); m_tc = 1'b1; end
          else if (nv < 0) begin nv = nv + (MAXV + 1); m_tc = 1'b1; end
          m_cnt = nv;
        end
        2'd1: if (e) begin
          if (nv > MAXV) begin nv = MAXV; m_tc = 1'b1; end
          else if (nv < 0) begin nv = 0; m_tc = 1'b1; end
          m_cnt = nv;
        end
        2'd2: if (e && m_st == S_RUN) begin
          if (nv > MAXV) nv = MAXV;
          if (nv < 0) nv = 0;
          m_cnt = nv;
          if (nv == (d ? MAXV : 0)) begin m_st = S_DONE; m_tc = 1'b1; end
        end
        default: ;
      endcase
    end
  endtask

  task automatic drive(input bit e, input bit d, input bit [1:0] md, input bit l, input int lv);
    exp_t x;
    @(negedge clk);
    enable = e; direction = d; mode = md; load = l; load_value = 8'(lv);
    model(e, d, md, l, lv);
    x.cnt = m_cnt; x.tc = m_tc; x.busy = (m_st == S_RUN);
    sb.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      mon_x = sb.pop_front();
      n_checks++;
      if (count_out !== 8'(mon_x.cnt) || tc !== mon_x.tc || busy !== mon_x.busy) begin
        n_fail++;
        $display("FAIL scoreboard @%0t: got cnt=%0d tc=%b busy=%b, want cnt=%0d tc=%b busy=%b",
                 $time, count_out, tc, busy, mon_x.cnt, mon_x.tc, mon_x.busy);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  bit       r_en, r_dir, r_ld;
  bit [1:0] r_md;
  int       r_lv;

  initial begin
    #1;
    chk("reset_count", 32'(count_out), 0);
    chk("reset_tc", 32'(tc), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_def_count", 32'(d_count), 0);
    @(negedge clk); rst = 1'b0;

    // wrap: 8 ->up 1 ->down 8 -> 5 -> 2
    drive(0, 0, 2'd0, 1, 8);
    drive(1, 1, 2'd0, 0, 0);
    drive(1, 0, 2'd0, 0, 0);
    drive(1, 0, 2'd0, 0, 0);
    drive(1, 0, 2'd0, 0, 0);
    // saturate: pinned at 9, then 2 down to 0
    drive(0, 1, 2'd1, 1, 8);
    repeat (3) drive(1, 1, 2'd1, 0, 0);
    drive(0, 0, 2'd1, 1, 2);
    drive(1, 0, 2'd1, 0, 0);
    // one-shot down from 5, then reload 7, then load already at terminal
    drive(0, 0, 2'd2, 1, 5);
    drive(1, 0, 2'd2, 0, 0);
    drive(1, 0, 2'd2, 0, 0);
    drive(1, 0, 2'd2, 0, 0);
    drive(1, 1, 2'd2, 0, 0);
    drive(0, 1, 2'd2, 1, 7);
    drive(0, 1, 2'd2, 1, 9);
    drive(1, 1, 2'd2, 0, 0);
    // load clip beats enable, hold freezes
    drive(1, 1, 2'd0, 1, 12);
    drive(1, 1, 2'd3, 0, 0);
    drive(1, 0, 2'd3, 0, 0);
    // asynchronous reset mid-run
    drive(0, 1, 2'd2, 1, 3);
    drive(1, 1, 2'd2, 0, 0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_rst_count", 32'(count_out), 0);
    chk("async_rst_tc", 32'(tc), 0);
    chk("async_rst_busy", 32'(busy), 0);
    m_cnt = 0; m_st = S_IDLE;
    #1 rst = 1'b0;
    drive(1, 1, 2'd2, 0, 0);
    drive(1, 1, 2'd2, 0, 0);

    // randomized traffic
    r_md = 2'd0; r_dir = 1'b1;
    repeat (1500) begin
      if ($urandom_range(0, 15) == 0) r_md = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) r_dir = ~r_dir;
      r_en = ($urandom_range(0, 3) != 0);
      r_ld = ($urandom_range(0, 5) == 0);
      r_lv = $urandom_range(0, 15);
      drive(r_en, r_dir, r_md, r_ld, r_lv);
    end

    // default parameters: 255 wraps to 0 and back
    @(negedge clk); d_load = 1'b1; d_load_value = 8'd255;
    @(posedge clk); #1;
    chk("def_load_count", 32'(d_count), 255);
    chk("def_load_tc", 32'(d_tc), 0);
    @(negedge clk); d_load = 1'b0; d_enable = 1'b1; d_direction = 1'b1;
    @(posedge clk); #1;
    chk("def_up_wrap_count", 32'(d_count), 0);
    chk("def_up_wrap_tc", 32'(d_tc), 1);
    @(negedge clk); d_direction = 1'b0;
    @(posedge clk); #1;
    chk("def_down_wrap_count", 32'(d_count), 255);
    chk("def_down_wrap_tc", 32'(d_tc), 1);
    @(negedge clk); d_enable = 1'b0;
    @(posedge clk); #1;
    chk("def_idle_count", 32'(d_count), 255);
    chk("def_idle_tc", 32'(d_tc), 0);

    @(posedge clk); #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
